// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: default bit period and FSM state encoding.
// The transmitter uses the same default bit period.
package uart_rx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the output idles at a known level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/ack holding register,
// framing-error and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       ACK,
    output logic [7:0] RX_OUT,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_s;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       out_nxt;
    logic             valid_nxt;
    logic             ferr_nxt;
    logic             ovr_nxt;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(CLK),
        .rst(RST),
        .d  (RX_IN),
        .q  (rx_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            RX_OUT    <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            RX_OUT    <= out_nxt;
            VALID     <= valid_nxt;
            FRAME_ERR <= ferr_nxt;
            OVERRUN   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        out_nxt   = RX_OUT;
        valid_nxt = VALID & ~ACK;
        ferr_nxt  = 1'b0;
        ovr_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end

            START: begin
                if (cnt == CNT_HALF) begin
                    if (!rx_s) begin
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    shreg_nxt[idx] = rx_s;
                    cnt_nxt        = '0;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        // A same-cycle ACK consumes the old byte, so it is not an overrun.
                        out_nxt   = shreg;
                        valid_nxt = 1'b1;
                        ovr_nxt   = VALID & ~ACK;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        BUSY = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16-clock-per-bit instance for the functional
// cases and a default-rate instance fed by a behavioural transmitter.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] rx_out;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    logic       rx_lb;
    logic       ack_lb;
    logic [7:0] rx_out_lb;
    logic       valid_lb;
    logic       ferr_lb;
    logic       ovr_lb;
    logic       busy_lb;

    int checks = 0;
    int errors = 0;
    int ferr_cyc = 0;
    int ovr_cyc = 0;
    int ferr_lb_cyc = 0;

    uart_rx #(
        .CLKS_PER_BIT(16)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .RX_IN    (rx),
        .ACK      (ack),
        .RX_OUT   (rx_out),
        .VALID    (valid),
        .FRAME_ERR(ferr),
        .OVERRUN  (ovr),
        .BUSY     (busy)
    );

    uart_rx #(
        .CLKS_PER_BIT(434)
    ) dut_lb (
        .CLK      (clk),
        .RST      (rst),
        .RX_IN    (rx_lb),
        .ACK      (ack_lb),
        .RX_OUT   (rx_out_lb),
        .VALID    (valid_lb),
        .FRAME_ERR(ferr_lb),
        .OVERRUN  (ovr_lb),
        .BUSY     (busy_lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of the pulse outputs; one event must give exactly one cycle.
    always @(negedge clk) begin
        if (ferr === 1'b1)    ferr_cyc++;
        if (ovr === 1'b1)     ovr_cyc++;
        if (ferr_lb === 1'b1) ferr_lb_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int cpb, input bit lb);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (lb) rx_lb = bits[i];
            else    rx    = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] lb_got [3];

    initial begin
        int n;
        int f0;
        int o0;

        rx     = 1'b1;
        ack    = 1'b0;
        rx_lb  = 1'b1;
        ack_lb = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_rx_out", rx_out, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", ferr, 1'b0);
        check("rst_overrun", ovr, 1'b0);
        check("rst_busy", busy, 1'b0);

        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte with latency measurement: 2 + 1 + 8 + 9*16 = 155 cycles.
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, 16, 1'b0);
            begin
                while (valid !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("a5_latency", n, 155);
        check("a5_rx_out", rx_out, 8'hA5);
        check("a5_valid", valid, 1'b1);
        check("a5_frame_err_cnt", ferr_cyc, 0);
        check("a5_overrun_cnt", ovr_cyc, 0);

        do_ack();
        check("ack_clears_valid", valid, 1'b0);

        // Glitch shorter than half a bit.
        f0 = ferr_cyc;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_rises", busy, 1'b1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_falls", busy, 1'b0);
        check("glitch_no_valid", valid, 1'b0);
        check("glitch_no_ferr", ferr_cyc, f0);

        // Framing error followed by a held-low line, then a clean byte.
        send_frame(8'h3C, 1'b0, 16, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr_wait_high_busy", busy, 1'b1);
        check("ferr_pulse_cycles", ferr_cyc, f0 + 1);
        check("ferr_no_valid", valid, 1'b0);
        check("ferr_rx_out_kept", rx_out, 8'hA5);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_exit_wait_high", busy, 1'b0);
        repeat (4) @(negedge clk);
        send_frame(8'h55, 1'b1, 16, 1'b0);
        repeat (2) @(negedge clk);
        check("after_ferr_rx_out", rx_out, 8'h55);
        check("after_ferr_valid", valid, 1'b1);
        check("after_ferr_no_new_ferr", ferr_cyc, f0 + 1);

        // Overrun: second byte lands while the first is unread.
        do_ack();
        o0 = ovr_cyc;
        send_frame(8'h11, 1'b1, 16, 1'b0);
        repeat (2) @(negedge clk);
        check("ovr_first_byte", rx_out, 8'h11);
        send_frame(8'h22, 1'b1, 16, 1'b0);
        repeat (2) @(negedge clk);
        check("ovr_pulse_cycles", ovr_cyc, o0 + 1);
        check("ovr_rx_out", rx_out, 8'h22);
        check("ovr_valid", valid, 1'b1);

        // ACK coincides with the stop sample of the second byte (edge 155).
        do_ack();
        send_frame(8'h11, 1'b1, 16, 1'b0);
        repeat (2) @(negedge clk);
        o0 = ovr_cyc;
        fork
            send_frame(8'h22, 1'b1, 16, 1'b0);
            begin
                repeat (154) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        check("ack_stop_no_overrun", ovr_cyc, o0);
        check("ack_stop_valid", valid, 1'b1);
        check("ack_stop_rx_out", rx_out, 8'h22);

        // Reset during data bit 3 of 8'hF0 (bit occupies cycles 64..79 of the frame).
        fork
            send_frame(8'hF0, 1'b1, 16, 1'b0);
            begin
                repeat (70) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("midrst_rx_out", rx_out, 8'h00);
                check("midrst_valid", valid, 1'b0);
                check("midrst_busy", busy, 1'b0);
                check("midrst_frame_err", ferr, 1'b0);
                check("midrst_overrun", ovr, 1'b0);
            end
        join
        repeat (16 * 14) @(negedge clk);
        if (valid === 1'b1) do_ack();
        check("post_rst_idle", busy, 1'b0);
        send_frame(8'h81, 1'b1, 16, 1'b0);
        repeat (2) @(negedge clk);
        check("post_rst_rx_out", rx_out, 8'h81);
        check("post_rst_valid", valid, 1'b1);
        do_ack();

        // Loopback at the default rate, three frames back to back.
        f0 = ferr_lb_cyc;
        fork
            begin
                send_frame(8'h00, 1'b1, 434, 1'b1);
                send_frame(8'hFF, 1'b1, 434, 1'b1);
                send_frame(8'h5A, 1'b1, 434, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    n = 0;
                    while (valid_lb !== 1'b1 && n < 6000) begin
                        @(negedge clk);
                        n++;
                    end
                    lb_got[k] = (valid_lb === 1'b1) ? rx_out_lb : 8'hxx;
                    ack_lb = 1'b1;
                    @(negedge clk);
                    ack_lb = 1'b0;
                    @(negedge clk);
                end
            end
        join
        repeat (4) @(negedge clk);
        check("lb_byte0", lb_got[0], 8'h00);
        check("lb_byte1", lb_got[1], 8'hFF);
        check("lb_byte2", lb_got[2], 8'h5A);
        check("lb_no_frame_err", ferr_lb_cyc, f0);
        check("lb_valid_cleared", valid_lb, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the UART transmitter on the same serial link: it samples the incoming line RX_IN, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) and presents each byte to the local consumer through a valid/acknowledge holding register. It runs in the transmitter's clock domain with the same bit period: 434 CLK cycles per bit. It flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, 434, CLK cycles per serial bit; must be ≥ 8.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- RX_IN  in  1  asynchronous serial line; idles high.
- ACK  in  1  consumer has taken RX_OUT; clears VALID.
- RX_OUT  out  8  last good received byte; reset 8'h00.
- VALID  out  1  RX_OUT holds an unread byte (level); reset 0.
- FRAME_ERR  out  1  one-cycle pulse when the stop bit samples low; reset 0.
- OVERRUN  out  1  one-cycle pulse when an unread byte is overwritten; reset 0.
- BUSY  out  1  high in every state except IDLE; reset 0.

## Operation
- Input path: RX_IN goes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized bit `rx_s`.
- HALF = CLKS_PER_BIT/2, using integer division. The bit counter `cnt` is $clog2(CLKS_PER_BIT) bits wide. The bit index `idx` is 3 bits wide.
- State machine states and transitions:
  - IDLE: when `rx_s` = 0, set `cnt` = 0 and go to START.
  - START: at `cnt` == HALF-1, check `rx_s`.
    - If 0: go to DATA with `cnt` = 0 and `idx` = 0.
    - If 1 (glitch): return to IDLE. No outputs change.
    - Otherwise increment `cnt`.
  - DATA: at `cnt` == CLKS_PER_BIT-1, shift `rx_s` into `shreg[idx]` and clear `cnt`. If `idx` == 7, go to STOP; otherwise increment `idx`.
  - STOP: at `cnt` == CLKS_PER_BIT-1, sample `rx_s`.
    - If 1: load RX_OUT ← `shreg`, set VALID = 1, go to IDLE.
    - If 0: pulse FRAME_ERR, leave RX_OUT and VALID unchanged, go to WAIT_HIGH.
  - WAIT_HIGH (break recovery): stay until `rx_s` = 1, then go to IDLE.
- Holding register:
  - ACK while VALID = 1 clears VALID on the next edge.
  - ACK while VALID = 0 is ignored.
- Simultaneous events:
  - Good stop bit with VALID = 1 and no ACK: load the new byte, keep VALID = 1, pulse OVERRUN.
  - Good stop bit with VALID = 1 and ACK: load the new byte, keep VALID = 1, no OVERRUN.
  - FRAME_ERR in the same cycle as ACK: VALID clears as normal.
- Reset mid-frame: everything returns to its reset value within one cycle. The FSM restarts in IDLE.
  - If the line is low at release, the synchronizer output reaches 0 after 2 edges and the receiver resynchronizes on that false start.
  - Frame integrity is then not guaranteed and is not checked.

## Timing
- The start edge is seen in IDLE 2 cycles after RX_IN falls (synchronizer delay).
- The start bit is checked HALF cycles after entering START, i.e. at mid-bit.
- Each data bit and the stop bit is sampled CLKS_PER_BIT cycles after the previous sample, so every sample is near mid-bit.
- VALID and RX_OUT update on the edge after the stop sample.
- Total latency from the RX_IN falling edge to VALID: 2 + 1 + HALF + 9·CLKS_PER_BIT cycles, with ±1 cycle of input phase uncertainty.
- FRAME_ERR and OVERRUN are exactly one cycle wide.
- Back-to-back frames: IDLE is re-entered right after STOP. A start bit beginning within the second half of the stop bit is accepted.
- Baud tolerance follows from mid-bit sampling: about ±4% cumulative mismatch with the transmitter.

## Structure
- Shared header (`uart_defs.vh`) holds:
  - the default CLKS_PER_BIT value (434), which the transmitter also uses;
  - the receiver state encoding as localparams: IDLE, START, DATA, STOP, WAIT_HIGH.
- The one natural sub-module is `sync_2ff`, a 2-flop synchronizer with a reset value parameter. It is reusable for other asynchronous inputs.
- The FSM, counters, shift register and holding register stay in `uart_rx`.
- Target size: about 150–250 lines.

## Test plan
- Single byte: CLKS_PER_BIT = 16, drive frame 8'hA5 with stop = 1.
  - Expect RX_OUT = 8'hA5 and VALID = 1 at 2+1+8+144 cycles (±1) after the falling edge.
  - Expect FRAME_ERR = 0 and OVERRUN = 0.
- Glitch: a 5-cycle low pulse on an idle line (CLKS_PER_BIT = 16).
  - Expect BUSY to rise then return to 0 with no VALID and no FRAME_ERR.
- Framing error: byte 8'h3C with stop = 0, then the line held low for 40 cycles, then 8'h55 sent normally.
  - Expect one FRAME_ERR pulse and the FSM held in WAIT_HIGH until the line goes high.
  - Expect RX_OUT = 8'h55 and VALID = 1 afterwards; 8'h3C is never presented.
- Overrun and ACK interplay: send 8'h11 with no ACK, then 8'h22.
  - Expect an OVERRUN pulse and RX_OUT = 8'h22.
  - Repeat with ACK coinciding with the second stop sample: no OVERRUN, VALID = 1.
- Reset mid-frame: assert RST for 1 cycle during data bit 3 of 8'hF0.
  - Expect all outputs at reset values on the next edge.
  - A following clean frame 8'h81 must be received correctly.
- Loopback: transmitter output wired to RX_IN, default 434 cycles per bit, bytes 8'h00, 8'hFF, 8'h5A sent back-to-back with ACK given each time.
  - Expect all three bytes received in order with no FRAME_ERR.
